ppwm_exec: RTL
==============

// Module: ppwm_exec
// PURPOSE
//  Parametrised programmable-PWM sequencer: fetches 3-bit command words (ppwm_pkg::command_e),
//  executes one per cycle on a PWM value and a scratch register, drives one PWM output from a
//  free-running period counter. Generalises width/program depth; adds center-aligned mode,
//  multi-period WAIT, saturating arithmetic, inverted branch and synchronous restart.
// PARAMETERS
//  DATA_W   8  width of PWM value, register, counter and immediate
//  PC_W     4  program counter width (depth 2**PC_W, external memory)
//  CENTER   0  0: edge-aligned up counter; 1: center-aligned up/down counter
// PORTS
//  clk_i         in   1             clock
//  rst_ni        in   1             async active-low reset
//  en_i          in   1             1: sequencer executes; 0: sequencer stalls (counter/PWM run)
//  restart_i     in   1             sync: pc<=0, state RUN, flag<=0, wait count cleared
//  instr_addr_o  out  PC_W          program address (= pc_q)
//  instr_i       in   DATA_W+4      {cmd[3], tgt[1], imm[DATA_W]}, valid combinationally same cycle
//  pwm_o         out  1             PWM output
//  period_o      out  1             1-cycle pulse while counter==0 (period start)
//  waiting_o     out  1             sequencer in WAIT state
//  reg_o         out  DATA_W        scratch register value
// BEHAVIOUR
//  Reset: pc, pwm_q, shadow_q, reg_q, cntr_q, flag, wait_cnt = 0; state RUN; dir up; pwm_o=0,
//   period_o=1 (cntr==0), waiting_o=0, instr_addr_o=0.
//  Counter: edge: 0..2**DATA_W-1, wraps. center: 0,1..MAX..1,0,1..; period 2*MAX.
//   tick = last cycle of period (edge: cntr==MAX; center: cntr==1 counting down).
//  Shadow: on tick edge shadow_q<=pwm_q (value before that edge). pwm_o = cntr_q < shadow_q;
//   PWM writes take effect from next period start. 0 -> always low; MAX -> high MAX of 2**DATA_W.
//  Sequencer (state RUN, en_i=1, restart_i=0): instr executed in fetch cycle, results next cycle.
//   tgt: 0=PWM value, 1=register ("T" below). sext = sign-extend imm to width.
//   NOP: pc+1.  SET: T<=imm; pc+1.
//   ARITH: T<=T+sext(imm), saturating to [0, 2**DATA_W-1]; pc+1.
//   SHIFT: imm[DATA_W-1]=0 left, 1 right, logical, amount imm[$clog2(DATA_W)-1:0]; pc+1.
//   WAIT: wait_cnt<=(imm==0)?1:imm; state WAIT; pc unchanged. A tick in the issue cycle
//    does not count.
//   JUMP: pc<=pc+sext(imm) mod 2**PC_W (imm=0 -> self-loop).
//   CMP_CNTR: flag<=(cntr_q >= (tgt ? reg_q : imm)); pc+1.
//   BRANCH: taken if flag^tgt: pc<=pc+sext(imm), else pc+1. flag unchanged.
//  WAIT state: each tick decrements wait_cnt; on tick with wait_cnt==1 -> RUN, pc+1
//   (next instr runs in period_o cycle). waiting_o=1 throughout.
//  en_i=0: pc, regs, flag, state, wait_cnt frozen (ticks not counted); counter/shadow/pwm_o run.
//  restart_i has priority over en_i and any command; pwm_q/reg_q/shadow_q/cntr_q kept.
//  pc wraps mod 2**PC_W on pc+1. rst_ni low mid-WAIT or mid-period: all state to reset values.
// TESTING (DATA_W=8, PC_W=4, CENTER=0 unless noted)
//  1 Reset: rst_ni low mid-run -> pwm_o=0, instr_addr_o=0, reg_o=0, waiting_o=0 immediately.
//  2 Prog {SET PWM 64; WAIT 0; JUMP 0xFF}: pwm_o high cycles 0..63 of every 256 from 2nd period;
//    instr_addr_o cycles 1->2->1, waiting_o high between ticks.
//  3 SET PWM 250; ARITH PWM +10 -> pwm value 255; SET REG 3; ARITH REG 0xFB(-5) -> reg_o=0.
//  4 SET REG 0x81; SHIFT REG 0x01 -> reg_o=0x02; SET REG 0x80; SHIFT REG 0x83 -> reg_o=0x10.
//  5 CMP_CNTR imm 128 at cntr=100 -> flag 0; BRANCH tgt0 +3 not taken (pc+1); tgt1 taken (pc+3).
//  6 WAIT 3 then restart_i at 2nd tick -> pc=0, waiting_o=0 next cycle; CENTER=1 with pwm 64:
//    pwm_o high for 127 cycles centered on cntr==0 in 510-cycle period.

Source files
------------

// File: rtl/ppwm_exec.sv
// Programmable PWM sequencer: executes one command word per cycle against a PWM value and a
// scratch register, and drives a shadowed PWM output from a free-running period counter.
module ppwm_exec #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4,
    parameter bit CENTER = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              restart_i,
    output logic [PC_W-1:0]   instr_addr_o,
    input  logic [DATA_W+3:0] instr_i,
    output logic              pwm_o,
    output logic              period_o,
    output logic              waiting_o,
    output logic [DATA_W-1:0] reg_o
);

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_SET    = 3'd1;
    localparam logic [2:0] CMD_ARITH  = 3'd2;
    localparam logic [2:0] CMD_SHIFT  = 3'd3;
    localparam logic [2:0] CMD_WAIT   = 3'd4;
    localparam logic [2:0] CMD_JUMP   = 3'd5;
    localparam logic [2:0] CMD_CMP    = 3'd6;
    localparam logic [2:0] CMD_BRANCH = 3'd7;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DATA_W-1:0] MAX = '1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [0:0]        state_q, state_d;
    logic              flag_q, flag_d;
    logic [DATA_W-1:0] wait_cnt_q, wait_d;
    logic [DATA_W-1:0] pwm_q, pwm_d;
    logic [DATA_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] cntr_q;
    logic              dir_q;
    logic              tick;

    logic [2:0]        cmd;
    logic              tgt;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] tval;
    logic [DATA_W+1:0] sum;
    logic [SH_W-1:0]   amt;
    logic [PC_W-1:0]   pc_inc, pc_rel;
    logic              wr;
    logic [DATA_W-1:0] wr_val;

    assign cmd    = instr_i[DATA_W+3:DATA_W+1];
    assign tgt    = instr_i[DATA_W];
    assign imm    = instr_i[DATA_W-1:0];
    assign tval   = tgt ? reg_q : pwm_q;
    assign sum    = {2'b00, tval} + {{2{imm[DATA_W-1]}}, imm};
    assign amt    = imm[SH_W-1:0];
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_rel = pc_q + PC_W'($signed(imm));

    // Tick marks the last cycle of a period; in center mode that is cntr==1 on the way down.
    assign tick = CENTER ? (!dir_q && cntr_q == DATA_W'(1)) : (cntr_q == MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cntr_q   <= '0;
            dir_q    <= 1'b1;
            shadow_q <= '0;
        end else begin
            if (tick) shadow_q <= pwm_q;
            if (!CENTER) begin
                cntr_q <= cntr_q + DATA_W'(1);
                dir_q  <= 1'b1;
            end else if (dir_q) begin
                if (cntr_q == MAX) begin
                    cntr_q <= cntr_q - DATA_W'(1);
                    dir_q  <= 1'b0;
                end else begin
                    cntr_q <= cntr_q + DATA_W'(1);
                end
            end else if (cntr_q == DATA_W'(1)) begin
                cntr_q <= '0;
                dir_q  <= 1'b1;
            end else begin
                cntr_q <= cntr_q - DATA_W'(1);
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        flag_d  = flag_q;
        wait_d  = wait_cnt_q;
        pwm_d   = pwm_q;
        reg_d   = reg_q;
        wr      = 1'b0;
        wr_val  = '0;
        if (restart_i) begin
            pc_d    = '0;
            state_d = ST_RUN;
            flag_d  = 1'b0;
            wait_d  = '0;
        end else if (en_i) begin
            if (state_q == ST_WAIT) begin
                if (tick) begin
                    if (wait_cnt_q == DATA_W'(1)) begin
                        state_d = ST_RUN;
                        pc_d    = pc_inc;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_cnt_q - DATA_W'(1);
                    end
                end
            end else begin
                case (cmd)
                    CMD_NOP: pc_d = pc_inc;
                    CMD_SET: begin
                        wr = 1'b1; wr_val = imm; pc_d = pc_inc;
                    end
                    CMD_ARITH: begin
                        wr     = 1'b1;
                        wr_val = sum[DATA_W+1] ? '0 : (sum[DATA_W] ? MAX : sum[DATA_W-1:0]);
                        pc_d   = pc_inc;
                    end
                    CMD_SHIFT: begin
                        wr     = 1'b1;
                        wr_val = imm[DATA_W-1] ? (tval >> amt) : (tval << amt);
                        pc_d   = pc_inc;
                    end
                    CMD_WAIT: begin
                        wait_d  = (imm == '0) ? DATA_W'(1) : imm;
                        state_d = ST_WAIT;
                    end
                    CMD_JUMP: pc_d = pc_rel;
                    CMD_CMP: begin
                        flag_d = (cntr_q >= (tgt ? reg_q : imm));
                        pc_d   = pc_inc;
                    end
                    CMD_BRANCH: pc_d = (flag_q ^ tgt) ? pc_rel : pc_inc;
                    default: pc_d = pc_inc;
                endcase
                if (wr) begin
                    if (tgt) reg_d = wr_val;
                    else     pwm_d = wr_val;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= '0;
            state_q    <= ST_RUN;
            flag_q     <= 1'b0;
            wait_cnt_q <= '0;
            pwm_q      <= '0;
            reg_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            flag_q     <= flag_d;
            wait_cnt_q <= wait_d;
            pwm_q      <= pwm_d;
            reg_q      <= reg_d;
        end
    end

    assign instr_addr_o = pc_q;
    assign pwm_o        = (cntr_q < shadow_q);
    assign period_o     = (cntr_q == '0);
    assign waiting_o    = (state_q == ST_WAIT);
    assign reg_o        = reg_q;

endmodule
